// File: rtl/mc_ctrl_fsm.sv
// Multicycle RV32I control unit: sequences fetch/decode/execute/memory/writeback,
// drives datapath selects and enables, and latches a sticky fault on illegal opcodes or memory timeouts.
module mc_ctrl_fsm #(
    parameter bit USE_MEM_READY = 1'b1,
    parameter int TIMEOUT       = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       zero,
    input  logic       lt,
    input  logic       ltu,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       AdrSrc,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       MemWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [2:0] ImmSrc,
    output logic       retire,
    output logic       fault,
    output logic [1:0] fault_cause
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [7:0] TO_LAST = (TIMEOUT == 0) ? 8'd0 : 8'(TIMEOUT - 1);

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
        S_EXECR, S_EXECI, S_ALUWB, S_BRANCH, S_JAL, S_JALR, S_JLINK,
        S_LUI, S_AUIPC, S_FAULT
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] wait_q, wait_d;
    logic       fault_q, fault_d;
    logic [1:0] cause_q, cause_d;

    logic ready_eff;
    logic in_mem_state;
    logic timeout_hit;
    logic taken;

    assign ready_eff    = USE_MEM_READY ? mem_ready : 1'b1;
    assign in_mem_state = (state_q == S_FETCH) || (state_q == S_MEMREAD) || (state_q == S_MEMWRITE);
    assign timeout_hit  = (TIMEOUT != 0) && in_mem_state && !ready_eff && (wait_q == TO_LAST);

    always_comb begin
        unique case (funct3)
            3'b000:  taken = zero;
            3'b001:  taken = !zero;
            3'b100:  taken = lt;
            3'b101:  taken = !lt;
            3'b110:  taken = ltu;
            3'b111:  taken = !ltu;
            default: taken = 1'b0;
        endcase
    end

    always_comb begin
        unique case (op)
            OP_LOAD, OP_IMM, OP_JALR: ImmSrc = 3'b000;
            OP_STORE:                 ImmSrc = 3'b001;
            OP_BRANCH:                ImmSrc = 3'b010;
            OP_JAL:                   ImmSrc = 3'b011;
            OP_LUI, OP_AUIPC:         ImmSrc = 3'b100;
            default:                  ImmSrc = 3'b000;
        endcase
    end

    // Next-state, wait counter and fault latching.
    always_comb begin
        state_d = state_q;
        fault_d = fault_q;
        cause_d = cause_q;
        unique case (state_q)
            S_FETCH:    state_d = ready_eff ? S_DECODE : state_q;
            S_DECODE: begin
                unique case (op)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_R:              state_d = S_EXECR;
                    OP_IMM:            state_d = S_EXECI;
                    OP_BRANCH:         state_d = S_BRANCH;
                    OP_JAL:            state_d = S_JAL;
                    OP_JALR:           state_d = S_JALR;
                    OP_LUI:            state_d = S_LUI;
                    OP_AUIPC:          state_d = S_AUIPC;
                    default: begin
                        state_d = S_FAULT;
                        fault_d = 1'b1;
                        cause_d = 2'b01;
                    end
                endcase
            end
            S_MEMADR:   state_d = (op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  state_d = ready_eff ? S_MEMWB : state_q;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: state_d = ready_eff ? S_FETCH : state_q;
            S_EXECR:    state_d = S_ALUWB;
            S_EXECI:    state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_BRANCH:   state_d = S_FETCH;
            S_JAL:      state_d = S_ALUWB;
            S_JALR:     state_d = S_JLINK;
            S_JLINK:    state_d = S_FETCH;
            S_LUI:      state_d = S_ALUWB;
            S_AUIPC:    state_d = S_ALUWB;
            S_FAULT:    state_d = S_FAULT;
            default:    state_d = S_FETCH;
        endcase
        if (timeout_hit) begin
            state_d = S_FAULT;
            fault_d = 1'b1;
            cause_d = 2'b10;
        end
        // Counter only runs while a memory state is stalled; any transition clears it.
        wait_d = 8'd0;
        if (in_mem_state && !ready_eff && (state_d == state_q))
            wait_d = (wait_q == 8'hFF) ? wait_q : wait_q + 8'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            wait_q  <= 8'd0;
            fault_q <= 1'b0;
            cause_q <= 2'b00;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            fault_q <= fault_d;
            cause_q <= cause_d;
        end
    end

    always_comb begin
        mem_req   = 1'b0;
        AdrSrc    = 1'b0;
        IRWrite   = 1'b0;
        PCWrite   = 1'b0;
        MemWrite  = 1'b0;
        RegWrite  = 1'b0;
        ResultSrc = 2'b00;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b00;
        ALUOp     = 2'b00;
        unique case (state_q)
            S_FETCH: begin
                mem_req   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                IRWrite   = ready_eff;
                PCWrite   = ready_eff;
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
            end
            S_MEMREAD: begin
                mem_req = 1'b1;
                AdrSrc  = 1'b1;
            end
            S_MEMWB: begin
                ResultSrc = 2'b01;
                RegWrite  = 1'b1;
            end
            S_MEMWRITE: begin
                mem_req  = 1'b1;
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
            end
            S_EXECR: begin
                ALUSrcA = 2'b10;
                ALUOp   = 2'b10;
            end
            S_EXECI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                ALUOp   = 2'b10;
            end
            S_ALUWB: RegWrite = 1'b1;
            S_BRANCH: begin
                ALUSrcA = 2'b10;
                ALUOp   = 2'b01;
                PCWrite = taken;
            end
            S_JAL: begin
                PCWrite = 1'b1;
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b10;
            end
            S_JALR: begin
                ALUSrcA   = 2'b10;
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                PCWrite   = 1'b1;
            end
            S_JLINK: begin
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                RegWrite  = 1'b1;
            end
            S_LUI: begin
                ALUSrcA = 2'b11;
                ALUSrcB = 2'b01;
            end
            S_AUIPC: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
            end
            default: ;
        endcase
        retire = (state_q != S_FETCH) && (state_q != S_FAULT) && (state_d == S_FETCH);
        // Reset is asynchronous, so enables must drop in the same cycle rst_n falls.
        if (!rst_n) begin
            mem_req  = 1'b0;
            IRWrite  = 1'b0;
            PCWrite  = 1'b0;
            MemWrite = 1'b0;
            RegWrite = 1'b0;
            retire   = 1'b0;
        end
    end

    assign fault       = fault_q;
    assign fault_cause = cause_q;

endmodule
